dac_driver_mc: RTL

DAC_DRIVER_MC -- requirements
Module: dac_driver_mc

---
 rtl/dac_driver_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dac_driver_mc.sv
// Multi-channel DAC word driver: GPIO register file, per-channel mode select
// (scaler / static / triggered / pattern) and sub-word sample delay.
module dac_driver_mc #(
  parameter int NUM_CH    = 2,
  parameter int SAMP_W    = 16,
  parameter int SPW       = 16,
  parameter int PAT_DEPTH = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  gpio_in,
  input  logic [NUM_CH*SAMP_W*SPW-1:0] scaler_in,
  input  logic [NUM_CH-1:0]            scaler_valid,
  input  logic                         del_trig,
  output logic [NUM_CH*SAMP_W*SPW-1:0] dac_out
);

  localparam int WORD_W = SAMP_W * SPW;
  localparam int SB     = WORD_W / 8;
  localparam int SBW    = $clog2(SB);
  localparam int PB     = PAT_DEPTH * SB;
  localparam int PW     = $clog2(PB);
  localparam int PIW    = $clog2(PAT_DEPTH);
  localparam int SHW    = $clog2(SPW);
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [16:0]    BASE17 = 17'(BASE_ADDR);
  localparam logic [7:0]     NCH8   = 8'(NUM_CH);
  localparam logic [7:0]     SHMAX8 = 8'(SPW - 1);
  localparam logic [SHW-1:0] SHMAX  = SHW'(SPW - 1);
  localparam logic [7:0]     LNMAX8 = 8'(PAT_DEPTH - 1);
  localparam logic [PIW-1:0] LNMAX  = PIW'(PAT_DEPTH - 1);

  typedef logic [WORD_W-1:0] word_t;

  logic [2:0]     sync_q, sync_d;
  logic           wr_q, wr_d;
  logic [7:0]     ch_sel_q, ch_sel_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [1:0]     mode_q  [NUM_CH];
  logic [1:0]     mode_d  [NUM_CH];
  logic [SHW-1:0] shift_q [NUM_CH];
  logic [SHW-1:0] shift_d [NUM_CH];
  logic [PIW-1:0] len_q   [NUM_CH];
  logic [PIW-1:0] len_d   [NUM_CH];
  logic [PIW-1:0] pidx_q  [NUM_CH];
  logic [PIW-1:0] pidx_d  [NUM_CH];
  logic [7:0]     stat_q  [NUM_CH][SB];
  logic [7:0]     stat_d  [NUM_CH][SB];
  logic [7:0]     pat_q   [NUM_CH][PB];
  logic [7:0]     pat_d   [NUM_CH][PB];
  word_t          st1_q   [NUM_CH];
  word_t          st1_d   [NUM_CH];
  word_t          prev_q  [NUM_CH];
  word_t          prev_d  [NUM_CH];
  word_t          dac_q   [NUM_CH];
  word_t          dac_d   [NUM_CH];

  logic [16:0]       rel;
  logic              in_map;
  logic [2:0]        off;
  logic [7:0]        data;
  logic              ch_ok;
  logic [CW-1:0]     chi;
  logic [SBW-1:0]    sptr_inc;
  logic [PIW-1:0]    rd_idx [NUM_CH];
  word_t             stat_w [NUM_CH];
  word_t             pat_w  [NUM_CH];
  logic [2*WORD_W-1:0] cat  [NUM_CH];
  logic              unused_gpio;

  assign rel         = {1'b0, gpio_in[15:0]} - BASE17;
  assign in_map      = (rel <= 17'd6);
  assign off         = rel[2:0];
  assign data        = gpio_in[23:16];
  assign ch_ok       = (ch_sel_q < NCH8);
  assign chi         = ch_sel_q[CW-1:0];
  assign sptr_inc    = ptr_q[SBW-1:0] + SBW'(1);
  assign unused_gpio = ^gpio_in[31:25];

  // Two-flop synchroniser plus one more stage for edge detection.
  assign sync_d = {sync_q[1:0], gpio_in[24]};
  assign wr_d   = sync_q[1] & ~sync_q[2];

  always_comb begin
    ch_sel_d = ch_sel_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    len_d    = len_q;
    stat_d   = stat_q;
    pat_d    = pat_q;
    if (wr_q && in_map) begin
      case (off)
        3'd0: ch_sel_d = data;
        3'd1: if (ch_ok) mode_d[chi] = data[1:0];
        3'd2: if (ch_ok) shift_d[chi] = (data > SHMAX8) ? SHMAX : SHW'(data);
        3'd3: ptr_d = PW'(data);
        3'd4: if (ch_ok) begin
          stat_d[chi][ptr_q[SBW-1:0]] = data;
          ptr_d = PW'(sptr_inc);
        end
        3'd5: if (ch_ok) begin
          pat_d[chi][ptr_q] = data;
          ptr_d = ptr_q + PW'(1);
        end
        3'd6: if (ch_ok) len_d[chi] = (data > LNMAX8) ? LNMAX : PIW'(data);
        default: ;
      endcase
    end
  end

  // A trigger in pattern mode restarts the sequence from word 0.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rd_idx[c] = del_trig ? '0 : pidx_q[c];
      stat_w[c] = '0;
      pat_w[c]  = '0;
      for (int b = 0; b < SB; b++) begin
        stat_w[c][b*8 +: 8] = stat_q[c][b];
        pat_w[c][b*8 +: 8]  = pat_q[c][{rd_idx[c], SBW'(b)}];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st1_d[c]  = '0;
      pidx_d[c] = '0;
      prev_d[c] = st1_q[c];
      unique case (mode_q[c])
        2'd0: if (scaler_valid[c]) st1_d[c] = scaler_in[c*WORD_W +: WORD_W];
        2'd1: st1_d[c] = stat_w[c];
        2'd2: if (del_trig) st1_d[c] = stat_w[c];
        default: begin
          st1_d[c] = pat_w[c];
          if (del_trig)
            pidx_d[c] = (len_q[c] == '0) ? '0 : PIW'(1);
          else if (pidx_q[c] >= len_q[c])
            pidx_d[c] = '0;
          else
            pidx_d[c] = pidx_q[c] + PIW'(1);
        end
      endcase
      // Window of {cur, prev} starting s samples before cur.
      cat[c] = {st1_q[c], prev_q[c]} >> ((SPW - int'(shift_q[c])) * SAMP_W);
      dac_d[c] = cat[c][WORD_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign dac_out[g*WORD_W +: WORD_W] = dac_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      wr_q     <= 1'b0;
      ch_sel_q <= '0;
      ptr_q    <= '0;
      mode_q   <= '{default: '0};
      shift_q  <= '{default: '0};
      len_q    <= '{default: '0};
      pidx_q   <= '{default: '0};
      stat_q   <= '{default: '0};
      pat_q    <= '{default: '0};
      st1_q    <= '{default: '0};
      prev_q   <= '{default: '0};
      dac_q    <= '{default: '0};
    end else begin
      sync_q   <= sync_d;
      wr_q     <= wr_d;
      ch_sel_q <= ch_sel_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      pidx_q   <= pidx_d;
      stat_q   <= stat_d;
      pat_q    <= pat_d;
      st1_q    <= st1_d;
      prev_q   <= prev_d;
      dac_q    <= dac_d;
    end
  end

endmodule
